// File: rtl/fdc_sector_server_pkg.sv
// fdc_sector_server_pkg: disk_sr/disk_cr bit map, sector size, CPC format ids and FSM states
package fdc_sector_server_pkg;
    localparam int SR_RD_A = 17;
    localparam int SR_RD_B = 18;
    localparam int SR_WR_A = 20;
    localparam int SR_WR_B = 21;
    localparam int SR_HEAD = 15;
    localparam int CR_DONE = 4;
    localparam int CR_NF = 3;
    localparam int SECTOR_BYTES = 512;
    localparam logic [7:0] FMT_DATA = 8'hC1;
    localparam logic [7:0] FMT_SYS = 8'h41;
    localparam logic [7:0] FMT_IBM = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_STREAM,
        S_WR_REQ,
        S_WR_STREAM,
        S_DONE
    } state_t;

    function automatic logic req_any(input logic [31:0] sr);
        return sr[SR_RD_A] | sr[SR_RD_B] | sr[SR_WR_A] | sr[SR_WR_B];
    endfunction
endpackage

// File: rtl/fdc_sector_server_lba_calc.sv
// fdc_sector_server_lba_calc: validates a latched sector address against the mounted image and maps it to a linear block
module fdc_sector_server_lba_calc #(
    parameter int TRACKS = 40,
    parameter int SIDES  = 1,
    parameter int SPT    = 9
) (
    input  logic        i_drv,
    input  logic [6:0]  i_cyl,
    input  logic        i_head,
    input  logic [7:0]  i_id,
    input  logic [1:0]  i_img_ready,
    input  logic [3:0]  i_fmt_hi,
    output logic        o_valid,
    output logic [31:0] o_lba
);
    logic [31:0] w_track;
    logic [3:0]  w_sec;

    // Sector ids are 1-based within a track and carry the format in the high nibble
    always_comb begin
        w_sec   = i_id[3:0];
        w_track = (32'(i_drv) * 32'(TRACKS) + 32'(i_cyl)) * 32'(SIDES) + 32'(i_head);
        o_lba   = w_track * 32'(SPT) + 32'(w_sec) - 32'd1;
        o_valid = i_img_ready[i_drv] && (32'(i_cyl) < 32'(TRACKS)) && (32'(i_head) < 32'(SIDES))
                  && (i_id[7:4] == i_fmt_hi) && (w_sec != 4'd0) && (32'(w_sec) <= 32'(SPT));
    end
endmodule

// File: rtl/fdc_sector_server.sv
// fdc_sector_server: services nec765 sector requests by moving 512-byte blocks between a block store and the FDC fifos
module fdc_sector_server
    import fdc_sector_server_pkg::*;
#(
    parameter int TRACKS  = 40,
    parameter int SIDES   = 1,
    parameter int SPT     = 9,
    parameter int TIMEOUT = 1 << 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_disk_sr,
    output logic [31:0] o_disk_cr,
    input  logic [1:0]  i_img_ready,
    input  logic [7:0]  i_img_first_id,
    output logic [7:0]  o_disk_data_in,
    output logic        o_disk_data_clkin,
    input  logic [7:0]  i_disk_data_out,
    output logic        o_disk_data_clkout,
    output logic [31:0] o_blk_lba,
    output logic        o_blk_rd,
    output logic        o_blk_wr,
    input  logic        i_blk_ack,
    input  logic        i_blk_dvalid,
    input  logic [7:0]  i_blk_rdata,
    input  logic        i_blk_wreq,
    output logic [7:0]  o_blk_wdata,
    output logic        o_blk_wvalid
);
    localparam int WD = $clog2(TIMEOUT) + 1;

    state_t        r_state, w_next;
    logic [7:0]    r_id;
    logic [6:0]    r_cyl;
    logic          r_head, r_drv, r_wr, r_nf, w_nf;
    logic [9:0]    r_cnt;
    logic [WD-1:0] r_wdog;
    logic [31:0]   r_lba, w_lba;
    logic [7:0]    r_data_in, r_wdata;
    logic          r_clkin, r_clkout, r_cap, r_wvalid;
    logic          w_valid, w_req, w_req_wr, w_req_drv, w_active, w_event, w_expire, w_last;
    logic          w_unused;

    assign w_req     = req_any(i_disk_sr);
    assign w_req_wr  = !(i_disk_sr[SR_RD_A] || i_disk_sr[SR_RD_B]);
    assign w_req_drv = i_disk_sr[SR_RD_A] ? 1'b0 : i_disk_sr[SR_RD_B] ? 1'b1 : !i_disk_sr[SR_WR_A];
    assign w_active  = r_state inside {S_RD_REQ, S_RD_STREAM, S_WR_REQ, S_WR_STREAM};
    assign w_event   = i_blk_ack | i_blk_dvalid | i_blk_wreq;
    assign w_expire  = (r_wdog == WD'(TIMEOUT - 1)) && !w_event;
    assign w_last    = r_cnt == 10'(SECTOR_BYTES - 1);
    assign w_unused  = ^{i_disk_sr[31:22], i_disk_sr[19], i_disk_sr[16]};

    fdc_sector_server_lba_calc #(
        .TRACKS(TRACKS),
        .SIDES (SIDES),
        .SPT   (SPT)
    ) u_lba (
        .i_drv      (r_drv),
        .i_cyl      (r_cyl),
        .i_head     (r_head),
        .i_id       (r_id),
        .i_img_ready(i_img_ready),
        .i_fmt_hi   (i_img_first_id[7:4]),
        .o_valid    (w_valid),
        .o_lba      (w_lba)
    );

    // State and not-found flag; reset drops every request and strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_nf    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_nf    <= w_nf;
        end
    end

    // Next state: expiry only counts when no store event arrived this cycle
    always_comb begin
        w_next = r_state;
        w_nf   = r_nf;
        case (r_state)
            S_IDLE:      w_next = w_req ? S_CHECK : S_IDLE;
            S_CHECK: begin
                w_next = !w_valid ? S_DONE : r_wr ? S_WR_REQ : S_RD_REQ;
                w_nf   = !w_valid;
            end
            S_RD_REQ: begin
                w_next = i_blk_ack ? S_RD_STREAM : w_expire ? S_DONE : S_RD_REQ;
                w_nf   = w_expire;
            end
            S_RD_STREAM: begin
                w_next = ((i_blk_dvalid && w_last) || w_expire) ? S_DONE : S_RD_STREAM;
                w_nf   = w_expire;
            end
            S_WR_REQ: begin
                w_next = i_blk_ack ? S_WR_STREAM : w_expire ? S_DONE : S_WR_REQ;
                w_nf   = w_expire;
            end
            S_WR_STREAM: begin
                w_next = ((i_blk_wreq && w_last) || w_expire) ? S_DONE : S_WR_STREAM;
                w_nf   = w_expire;
            end
            S_DONE:      w_next = w_req ? S_DONE : S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Request latch, byte counting, watchdog and the fifo strobe pipelines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_cyl     <= '0;
            r_head    <= 1'b0;
            r_drv     <= 1'b0;
            r_wr      <= 1'b0;
            r_lba     <= '0;
            r_cnt     <= '0;
            r_wdog    <= '0;
            r_data_in <= '0;
            r_clkin   <= 1'b0;
            r_clkout  <= 1'b0;
            r_cap     <= 1'b0;
            r_wdata   <= '0;
            r_wvalid  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_id   <= i_disk_sr[7:0];
                r_cyl  <= i_disk_sr[14:8];
                r_head <= i_disk_sr[SR_HEAD];
                r_drv  <= w_req_drv;
                r_wr   <= w_req_wr;
            end
            if (r_state == S_CHECK)
                r_lba <= w_lba;
            r_cnt   <= (r_state == S_CHECK) ? '0
                     : ((r_state == S_RD_STREAM && i_blk_dvalid) || (r_state == S_WR_STREAM && i_blk_wreq)) ? r_cnt + 10'd1
                     : r_cnt;
            r_wdog  <= (!w_active || w_event) ? '0 : r_wdog + 1'b1;
            r_clkin <= r_state == S_RD_STREAM && i_blk_dvalid;
            if (r_state == S_RD_STREAM && i_blk_dvalid)
                r_data_in <= i_blk_rdata;
            r_clkout <= r_state == S_WR_STREAM && i_blk_wreq;
            r_cap    <= r_clkout;
            r_wvalid <= r_cap;
            if (r_cap)
                r_wdata <= i_disk_data_out;
        end
    end

    // Status word: format id of the selected drive plus done/not-found while in DONE
    always_comb begin
        o_disk_cr          = '0;
        o_disk_cr[31:24]   = i_img_ready[r_drv] ? i_img_first_id : 8'h00;
        o_disk_cr[CR_DONE] = r_state == S_DONE;
        o_disk_cr[CR_NF]   = r_state == S_DONE && r_nf;
    end

    assign o_blk_rd           = r_state == S_RD_REQ;
    assign o_blk_wr           = r_state == S_WR_REQ;
    assign o_blk_lba          = r_lba;
    assign o_disk_data_in     = r_data_in;
    assign o_disk_data_clkin  = r_clkin;
    assign o_disk_data_clkout = r_clkout;
    assign o_blk_wdata        = r_wdata;
    assign o_blk_wvalid       = r_wvalid;
endmodule

// File: tb/tb_fdc_sector_server.sv
// tb_fdc_sector_server: randomized bench checking the sector server against a model built from the addressing and transfer rules
module tb_fdc_sector_server;
    import fdc_sector_server_pkg::*;

    localparam int TRACKS  = 40;
    localparam int SIDES   = 1;
    localparam int SPT     = 9;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [31:0] disk_sr = '0, disk_cr, blk_lba;
    logic [1:0]  img_ready = '0;
    logic [7:0]  img_first_id = '0;
    logic [7:0]  disk_data_in, disk_data_out = '0, blk_rdata = '0, blk_wdata;
    logic        disk_data_clkin, disk_data_clkout, blk_rd, blk_wr, blk_wvalid;
    logic        blk_ack = 1'b0, blk_dvalid = 1'b0, blk_wreq = 1'b0;

    int          checks = 0, failures = 0, clkout_n = 0;
    logic [7:0]  fdc_fifo [4096];
    logic [7:0]  xb [512];
    logic [7:0]  rd_q [$];
    logic [7:0]  wr_q [$];
    bit          last_drv = 1'b0;

    always #5 clk = ~clk;

    fdc_sector_server #(
        .TRACKS(TRACKS), .SIDES(SIDES), .SPT(SPT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_disk_sr(disk_sr), .o_disk_cr(disk_cr),
        .i_img_ready(img_ready), .i_img_first_id(img_first_id),
        .o_disk_data_in(disk_data_in), .o_disk_data_clkin(disk_data_clkin),
        .i_disk_data_out(disk_data_out), .o_disk_data_clkout(disk_data_clkout),
        .o_blk_lba(blk_lba), .o_blk_rd(blk_rd), .o_blk_wr(blk_wr), .i_blk_ack(blk_ack),
        .i_blk_dvalid(blk_dvalid), .i_blk_rdata(blk_rdata), .i_blk_wreq(blk_wreq),
        .o_blk_wdata(blk_wdata), .o_blk_wvalid(blk_wvalid)
    );

    // Collect bytes strobed into the FDC read fifo and handed to the store, count write-fifo pops
    always @(negedge clk) begin
        if (disk_data_clkin) rd_q.push_back(disk_data_in);
        if (blk_wvalid) wr_q.push_back(blk_wdata);
        if (disk_data_clkout) clkout_n++;
    end

    // FDC write fifo: popped byte is valid only in the cycle after the pop strobe
    always @(posedge clk)
        disk_data_out <= disk_data_clkout ? fdc_fifo[(clkout_n - 1) & 4095] : 8'($urandom);

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    function automatic logic [7:0] exp_fmt();
        return img_ready[last_drv] ? img_first_id : 8'h00;
    endfunction

    task automatic send_bytes(input bit wr, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (wr) blk_wreq = 1'b1;
            else begin
                blk_dvalid = 1'b1;
                blk_rdata  = xb[i];
            end
            @(negedge clk);
            blk_wreq   = 1'b0;
            blk_dvalid = 1'b0;
            blk_rdata  = 8'($urandom);
        end
    endtask

    task automatic pulse_ack();
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] sr, output bit seen);
        int c;
        @(negedge clk);
        disk_sr = sr;
        c = 0;
        while (c < 6 && !blk_rd) begin
            @(negedge clk);
            c++;
        end
        seen = blk_rd;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL start_req: blk_rd got 0 expected 1 (sr=%h)", sr);
        end
    endtask

    task automatic do_xfer(input string nm, input logic [3:0] reqs, input int cyl, input bit head, input logic [7:0] id);
        int k, c, errs, base, n;
        bit wr, drv, ok;
        logic [31:0] lba;
        k = 0;
        while (k < 3 && !reqs[k]) k++;
        wr  = k >= 2;
        drv = (k % 2) == 1;
        ok  = img_ready[drv] && cyl < TRACKS && int'(head) < SIDES && id[7:4] == img_first_id[7:4]
              && int'(id[3:0]) >= 1 && int'(id[3:0]) <= SPT;
        lba = 32'(((int'(drv) * TRACKS + cyl) * SIDES + int'(head)) * SPT + int'(id[3:0]) - 1);
        last_drv = drv;
        rd_q.delete();
        wr_q.delete();
        base = clkout_n;
        for (int i = 0; i < 512; i++) begin
            xb[i] = 8'($urandom);
            fdc_fifo[(base + i) & 4095] = xb[i];
        end
        @(negedge clk);
        disk_sr = {10'b0, reqs[3], reqs[2], 1'b0, reqs[1], reqs[0], 1'b0, head, cyl[6:0], id};
        c = 0;
        while (c < 6 && !(blk_rd || blk_wr || disk_cr[4])) begin
            @(negedge clk);
            c++;
        end
        if (!ok) begin
            checks++;
            if (blk_rd !== 1'b0 || blk_wr !== 1'b0 || disk_cr[4:3] !== 2'b11 || c > 2) begin
                failures++;
                $display("FAIL %s not_found: rd=%b wr=%b cr[4:3]=%b after %0d cycles, expected rd=0 wr=0 cr[4:3]=11 within 2",
                         nm, blk_rd, blk_wr, disk_cr[4:3], c);
            end
        end else begin
            checks++;
            if (blk_rd !== !wr || blk_wr !== wr || disk_cr[4] !== 1'b0 || c > 2) begin
                failures++;
                $display("FAIL %s request: rd=%b wr=%b done=%b after %0d cycles, expected rd=%b wr=%b done=0",
                         nm, blk_rd, blk_wr, disk_cr[4], c, !wr, wr);
            end
            checks++;
            if (blk_lba !== lba) begin
                failures++;
                $display("FAIL %s lba: got %0d expected %0d", nm, blk_lba, lba);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if ((wr ? blk_wr : blk_rd) !== 1'b1) begin
                failures++;
                $display("FAIL %s req_hold: got 0 expected 1 before ack", nm);
            end
            pulse_ack();
            send_bytes(wr, 512);
            if (wr) begin
                blk_wreq = 1'b1;
                @(negedge clk);
                blk_wreq = 1'b0;
            end
            repeat (5) @(negedge clk);
            checks++;
            if (disk_cr[4:3] !== 2'b10) begin
                failures++;
                $display("FAIL %s done: cr[4:3] got %b expected 10", nm, disk_cr[4:3]);
            end
            n = wr ? wr_q.size() : rd_q.size();
            errs = (n == 512) ? 0 : 1;
            for (int i = 0; i < n && i < 512; i++)
                if ((wr ? wr_q[i] : rd_q[i]) !== xb[i]) errs++;
            checks++;
            if (errs != 0) begin
                failures++;
                $display("FAIL %s data: got %0d bytes with %0d errors, expected 512 exact", nm, n, errs);
            end
            if (wr) begin
                checks++;
                if (clkout_n - base != 512) begin
                    failures++;
                    $display("FAIL %s clkout_count: got %0d expected 512", nm, clkout_n - base);
                end
            end
        end
        checks++;
        if (disk_cr[31:24] !== exp_fmt()) begin
            failures++;
            $display("FAIL %s fmt_id: got %h expected %h", nm, disk_cr[31:24], exp_fmt());
        end
        disk_sr = '0;
        @(negedge clk);
        checks++;
        if (disk_cr[4:3] !== 2'b00) begin
            failures++;
            $display("FAIL %s release: cr[4:3] got %b expected 00", nm, disk_cr[4:3]);
        end
    endtask

    task automatic test_reset();
        img_ready    = 2'b01;
        img_first_id = FMT_DATA;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (disk_cr !== 32'hC100_0000) begin
            failures++;
            $display("FAIL reset_cr: got %h expected c1000000", disk_cr);
        end
        checks++;
        if ({disk_data_in, disk_data_clkin, disk_data_clkout, blk_lba, blk_rd, blk_wr, blk_wdata, blk_wvalid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero (lba=%h rd=%b wr=%b) expected all 0", blk_lba, blk_rd, blk_wr);
        end
        img_ready = 2'b10;
        #1;
        checks++;
        if (disk_cr !== 32'h0) begin
            failures++;
            $display("FAIL reset_cr_unready: got %h expected 0", disk_cr);
        end
        img_ready = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        last_drv = 1'b0;
    endtask

    task automatic test_read();
        img_ready    = 2'b01;
        img_first_id = FMT_DATA;
        do_xfer("rd_first", 4'b0001, 0, 1'b0, 8'hC1);
        do_xfer("rd_last", 4'b0001, 39, 1'b0, 8'hC9);
    endtask

    task automatic test_not_found();
        img_ready    = 2'b01;
        img_first_id = FMT_DATA;
        do_xfer("nf_sector", 4'b0001, 3, 1'b0, 8'hCA);
        do_xfer("nf_sector0", 4'b0001, 3, 1'b0, 8'hC0);
        do_xfer("nf_cyl", 4'b0001, 40, 1'b0, 8'hC2);
        do_xfer("nf_head", 4'b0001, 1, 1'b1, 8'hC2);
        do_xfer("nf_format", 4'b0001, 1, 1'b0, 8'h41);
        do_xfer("nf_drive", 4'b0010, 1, 1'b0, 8'hC2);
    endtask

    task automatic test_write();
        img_ready    = 2'b11;
        img_first_id = FMT_SYS;
        do_xfer("wr_b", 4'b1000, 2, 1'b0, 8'h41);
        do_xfer("wr_a", 4'b0100, 17, 1'b0, 8'h47);
    endtask

    task automatic test_priority();
        img_ready    = 2'b11;
        img_first_id = FMT_IBM;
        do_xfer("prio_rdb", 4'b0110, 5, 1'b0, 8'h03);
        do_xfer("prio_wra", 4'b1100, 6, 1'b0, 8'h04);
        do_xfer("prio_all", 4'b1111, 7, 1'b0, 8'h09);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int f, cyl;
            bit head;
            logic [7:0] id;
            logic [3:0] reqs;
            img_ready    = 2'($urandom_range(1, 3));
            f            = $urandom_range(0, 2);
            img_first_id = f == 0 ? FMT_DATA : f == 1 ? FMT_SYS : FMT_IBM;
            reqs         = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) begin
                cyl  = $urandom_range(0, TRACKS - 1);
                head = 1'b0;
                id   = {img_first_id[7:4], 4'($urandom_range(1, SPT))};
            end else begin
                cyl  = $urandom_range(0, 45);
                head = 1'($urandom);
                id   = {4'($urandom), 4'($urandom)};
            end
            do_xfer($sformatf("rand%0d", t), reqs, cyl, head, id);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int c;
        img_ready    = 2'b01;
        img_first_id = FMT_DATA;
        last_drv     = 1'b0;
        start_req(32'h0002_05C3, seen);
        c = 0;
        while (blk_rd && c < TIMEOUT + 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c < TIMEOUT - 1 || c > TIMEOUT + 1) begin
            failures++;
            $display("FAIL ack_timeout_len: blk_rd high %0d cycles expected %0d", c, TIMEOUT);
        end
        checks++;
        if (disk_cr[4:3] !== 2'b11) begin
            failures++;
            $display("FAIL ack_timeout_cr: cr[4:3] got %b expected 11", disk_cr[4:3]);
        end
        disk_sr = '0;
        @(negedge clk);
        rd_q.delete();
        for (int i = 0; i < 512; i++) xb[i] = 8'($urandom);
        start_req(32'h0002_01C5, seen);
        pulse_ack();
        send_bytes(1'b0, 10);
        c = 0;
        while (!disk_cr[4] && c < TIMEOUT + 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (disk_cr[4:3] !== 2'b11 || c < TIMEOUT - 5) begin
            failures++;
            $display("FAIL stream_timeout: cr[4:3] got %b after %0d cycles expected 11 after about %0d", disk_cr[4:3], c, TIMEOUT);
        end
        checks++;
        if (rd_q.size() != 10) begin
            failures++;
            $display("FAIL stream_partial: got %0d bytes expected 10", rd_q.size());
        end
        disk_sr = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        img_ready    = 2'b01;
        img_first_id = FMT_DATA;
        for (int i = 0; i < 512; i++) xb[i] = 8'($urandom);
        start_req(32'h0002_0AC2, seen);
        pulse_ack();
        send_bytes(1'b0, 200);
        checks++;
        if (disk_data_clkin !== 1'b1) begin
            failures++;
            $display("FAIL mid_strobe: clkin got %b expected 1 for byte 200", disk_data_clkin);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (disk_data_clkin !== 1'b0 || blk_rd !== 1'b0 || disk_cr[4] !== 1'b0 || disk_data_in !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: clkin=%b rd=%b done=%b data=%h expected all 0",
                     disk_data_clkin, blk_rd, disk_cr[4], disk_data_in);
        end
        disk_sr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        start_req(32'h0002_0AC2, seen);
        rst_n = 1'b0;
        #1;
        checks++;
        if (blk_rd !== 1'b0) begin
            failures++;
            $display("FAIL req_reset: blk_rd got %b expected 0", blk_rd);
        end
        disk_sr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        last_drv = 1'b0;
        do_xfer("after_reset", 4'b0001, 3, 1'b0, 8'hC4);
    endtask

    initial begin
        test_reset();
        test_read();
        test_not_found();
        test_write();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
